// File: rtl/burst_ram_emu_pkg.sv
// Shared definitions for the burst RAM controller emulation.
package burst_ram_emu_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // One-hot controller states
  typedef enum logic [3:0] {
    ST_INIT  = 4'b0001,
    ST_IDLE  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_READ  = 4'b1000
  } state_t;

  // Bits needed to count 0..n-1 (ceil(log2(n)), minimum 1)
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module burst_ram_array #(
  parameter int unsigned DEPTH_BITWIDTH = 8,
  parameter int unsigned DATA_BITWIDTH  = 64
) (
  input  logic                         clk,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH/8-1:0]   byte_en,
  input  logic [DATA_BITWIDTH-1:0]     wdata,
  output logic [DATA_BITWIDTH-1:0]     q
);

  localparam int unsigned BYTES = DATA_BITWIDTH / 8;
  localparam int unsigned WORDS = 2 ** DEPTH_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] mem [WORDS];

  // Byte-masked write and registered read; contents are never reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (byte_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/burst_ram_emu.sv
// Burst RAM controller emulation: fixed-latency read bursts, byte-masked write bursts.
module burst_ram_emu
  import burst_ram_emu_pkg::*;
#(
  parameter int unsigned DEPTH_BITWIDTH = 8,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned INIT_CYCLES    = 16
) (
  input  logic                         clk_ram,
  input  logic                         rst_n,
  input  logic                         cmd,
  input  logic                         cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH-1:0]     wr_data,
  input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
  output logic [DATA_BITWIDTH-1:0]     rd_data,
  output logic                         rd_data_valid,
  output logic                         busy
);

  localparam int unsigned BYTES   = DATA_BITWIDTH / 8;
  localparam int unsigned RD_CW   = cnt_width(READ_LATENCY + BURST_COUNT);
  localparam int unsigned INIT_CW = cnt_width(INIT_CYCLES);
  localparam int unsigned CNT_W   = (RD_CW > INIT_CW) ? RD_CW : INIT_CW;

  // Counter milestones; in READ the counter equals cycles since acceptance
  localparam logic [CNT_W-1:0] INIT_LAST      = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST        = CNT_W'(BURST_COUNT - 1);
  localparam logic [CNT_W-1:0] RD_LAST        = CNT_W'(READ_LATENCY + BURST_COUNT - 1);
  localparam logic [CNT_W-1:0] RD_FIRST_ISSUE = CNT_W'(READ_LATENCY - 2);
  localparam logic [CNT_W-1:0] RD_LAST_ISSUE  = CNT_W'(READ_LATENCY + BURST_COUNT - 3);

  state_t                      state, next_state;
  logic [CNT_W-1:0]            cnt, cnt_d;
  logic [DEPTH_BITWIDTH-1:0]   addr_q;
  logic [DEPTH_BITWIDTH-1:0]   mem_addr;
  logic [BYTES-1:0]            byte_en;
  logic [DATA_BITWIDTH-1:0]    mem_q;
  logic                        rd_issue, rd_issue_q;
  logic                        busy_d;
  logic                        accept;

  assign accept = (state == ST_IDLE) && cmd_en;

  burst_ram_array #(
    .DEPTH_BITWIDTH (DEPTH_BITWIDTH),
    .DATA_BITWIDTH  (DATA_BITWIDTH)
  ) u_array (
    .clk     (clk_ram),
    .addr    (mem_addr),
    .byte_en (byte_en),
    .wdata   (wr_data),
    .q       (mem_q)
  );

  // State, counters and registered outputs; reset aborts any burst in flight
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      cnt           <= '0;
      busy          <= 1'b1;
      addr_q        <= '0;
      rd_issue_q    <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      state         <= next_state;
      cnt           <= cnt_d;
      busy          <= busy_d;
      if (accept) addr_q <= addr;
      rd_issue_q    <= rd_issue;
      rd_data_valid <= rd_issue_q;
      if (rd_issue_q) rd_data <= mem_q;
    end
  end

  // Next-state selection; an undefined cmd falls through to read
  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT:  if (cnt == INIT_LAST) next_state = ST_IDLE;
      ST_IDLE: begin
        if (cmd_en) begin
          if (cmd == CMD_WRITE) next_state = ST_WRITE;
          else                  next_state = ST_READ;
        end
      end
      ST_WRITE: if (cnt == WR_LAST) next_state = ST_IDLE;
      ST_READ:  if (cnt == RD_LAST) next_state = ST_IDLE;
      default:  next_state = ST_INIT;
    endcase
  end

  // Array port steering, read issue window and counter update
  always_comb begin
    cnt_d    = cnt;
    mem_addr = addr;
    byte_en  = '0;
    rd_issue = 1'b0;
    busy_d   = (next_state != ST_IDLE);
    case (state)
      ST_INIT: begin
        cnt_d = (cnt == INIT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_en) begin
          cnt_d = CNT_W'(1);
          if (cmd == CMD_WRITE) byte_en = ~data_mask;
          else if (READ_LATENCY == 2) rd_issue = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_addr = addr_q + DEPTH_BITWIDTH'(cnt);
        byte_en  = ~data_mask;
        cnt_d    = (cnt == WR_LAST) ? '0 : cnt + CNT_W'(1);
      end
      ST_READ: begin
        mem_addr = addr_q + DEPTH_BITWIDTH'(cnt - RD_FIRST_ISSUE);
        rd_issue = (cnt >= RD_FIRST_ISSUE) && (cnt <= RD_LAST_ISSUE);
        cnt_d    = (cnt == RD_LAST) ? '0 : cnt + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_burst_ram_emu.sv
// Directed self-checking bench for burst_ram_emu (default parameters).
module tb_burst_ram_emu;
  import burst_ram_emu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd = 1'b0;
  logic        cmd_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  data_mask = '0;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap [4];
  int first_k, nvalid, busy_hi;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  burst_ram_emu dut (
    .clk_ram       (clk),
    .rst_n         (rst_n),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Called at the negedge where rst_n was just released; optionally pokes a write during INIT
  task automatic init_check(input bit poke);
    int  n;
    logic vseen;
    n = 0;
    vseen = 1'b0;
    while (busy && n < 40) begin
      vseen |= rd_data_valid;
      if (poke && n == 4) begin
        cmd_en = 1'b1; cmd = CMD_WRITE; addr = 8'h30;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF; data_mask = 8'h00;
      end else begin
        cmd_en = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    cmd_en = 1'b0;
    chk("init_busy_cycles", 64'(n), 64'd16);
    chk("init_valid_low", 64'(vseen), 64'd0);
  endtask

  task automatic wr_burst(input logic [7:0] a, input logic [255:0] d, input logic [31:0] m);
    wait_idle();
    cmd_en = 1'b1; cmd = CMD_WRITE; addr = a;
    wr_data = d[63:0]; data_mask = m[7:0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      wr_data = d[i*64 +: 64];
      data_mask = m[i*8 +: 8];
      chk("wr_busy_hi", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("wr_busy_lo", 64'(busy), 64'd0);
  endtask

  task automatic rd_burst(input logic [7:0] a, input bit intrude);
    wait_idle();
    cmd_en = 1'b1; cmd = CMD_READ; addr = a;
    first_k = 0; nvalid = 0; busy_hi = 0;
    for (int i = 0; i < 4; i++) cap[i] = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      if (intrude && k == 2) begin
        cmd_en = 1'b1; cmd = CMD_WRITE; addr = 8'h80;
        wr_data = 64'hBAD0_BAD0_BAD0_BAD0; data_mask = 8'h00;
      end
      if (busy) busy_hi++;
      if (rd_data_valid) begin
        if (nvalid == 0) first_k = k;
        if (nvalid < 4) cap[nvalid] = rd_data;
        nvalid++;
      end
    end
  endtask

  task automatic read_expect(input logic [7:0] a, input logic [255:0] e, input bit intrude);
    rd_burst(a, intrude);
    chk("rd_first_beat_cycle", 64'(first_k), 64'd3);
    chk("rd_beat_count", 64'(nvalid), 64'd4);
    chk("rd_busy_cycles", 64'(busy_hi), 64'd6);
    for (int i = 0; i < 4; i++) chk("rd_beat", cap[i], e[i*64 +: 64]);
    chk("rd_hold_last", rd_data, e[255:192]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_valid", 64'(rd_data_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    init_check(1'b0);

    // Basic write/read burst
    wr_burst(8'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'h0);
    read_expect(8'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);

    // Byte masking: upper four lanes masked on beat 0, all lanes masked on beats 1..3
    wr_burst(8'h20, {ONES, ONES, ONES, ONES}, 32'h0);
    wr_burst(8'h20, {64'h3, 64'h2, 64'h1, 64'h0}, {8'hFF, 8'hFF, 8'hFF, 8'hF0});
    read_expect(8'h20, {ONES, ONES, ONES, 64'hFFFF_FFFF_0000_0000}, 1'b0);

    // Address wrap at the top of memory
    wr_burst(8'h00, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 32'h0);
    wr_burst(8'hFE, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 32'h0);
    read_expect(8'hFE, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 1'b0);
    read_expect(8'h00, {64'hE3, 64'hE2, 64'hDDDD, 64'hCCCC}, 1'b0);

    // Write command during a read burst is ignored
    wr_burst(8'h80, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 32'h0);
    read_expect(8'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b1);
    read_expect(8'h80, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b0);

    // Reset at T+1 of a write: only beat 0 lands; a write during INIT is dropped
    wr_burst(8'h30, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 32'h0);
    wr_burst(8'h40, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 32'h0);
    wait_idle();
    cmd_en = 1'b1; cmd = CMD_WRITE; addr = 8'h40;
    wr_data = 64'h5550; data_mask = 8'h00;
    @(negedge clk);
    cmd_en = 1'b0; wr_data = 64'h5551;
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_valid", 64'(rd_data_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_check(1'b1);
    read_expect(8'h40, {64'hA3, 64'hA2, 64'hA1, 64'h5550}, 1'b0);
    read_expect(8'h30, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b0);

    // Reset during read beats drops rd_data_valid at once
    wait_idle();
    cmd_en = 1'b1; cmd = CMD_READ; addr = 8'h80;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_en = 1'b0;
    end
    chk("rdabort_valid_before", 64'(rd_data_valid), 64'd1);
    chk("rdabort_data_before", rd_data, 64'hC1);
    rst_n = 1'b0;
    #1;
    chk("rdabort_valid", 64'(rd_data_valid), 64'd0);
    chk("rdabort_rd_data", rd_data, 64'd0);
    chk("rdabort_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    init_check(1'b0);
    read_expect(8'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
